// File: rtl/rv32ima_pkg.sv
// Shared core types: word, load/store width codes, arbiter state.
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    localparam int LDST_WIDTH_W = 2;

    localparam logic [LDST_WIDTH_W-1:0] LDST_BYTE = 2'd0;
    localparam logic [LDST_WIDTH_W-1:0] LDST_HALF = 2'd1;
    localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IBUSY,
        ARB_DBUSY
    } arb_state_t;

    typedef struct packed {
        logic                    wr;
        word_t                   addr;
        word_t                   store;
        logic [LDST_WIDTH_W-1:0] width;
    } arb_req_t;

    function automatic arb_req_t fetch_req(input word_t addr);
        arb_req_t r;
        r.wr    = 1'b0;
        r.addr  = addr;
        r.store = '0;
        r.width = LDST_WORD;
        return r;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter onto one memory port; data has priority.
// Define MEM_ARB_FAIRNESS_EN to alternate grants when both ports request.
module memory_arbiter
    import rv32ima_pkg::*;
(
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    iren,
    input  word_t                   iaddr,
    output word_t                   idata,
    output logic                    ihit,
    input  logic                    dren,
    input  logic                    dwen,
    input  word_t                   daddr,
    input  word_t                   dstore,
    input  logic [LDST_WIDTH_W-1:0] dwidth,
    output word_t                   dload,
    output logic                    dhit,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output word_t                   mem_addr,
    output word_t                   mem_store,
    output logic [LDST_WIDTH_W-1:0] mem_width,
    input  word_t                   mem_load,
    input  logic                    mem_ready
);

    arb_state_t state;
    arb_req_t   req;
    logic       dreq;
    logic       dgrant;

    assign dreq = dren | dwen;

`ifdef MEM_ARB_FAIRNESS_EN
    logic last_was_data;
    assign dgrant = dreq & ~(iren & last_was_data);
`else
    assign dgrant = dreq;
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= ARB_IDLE;
            req   <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
            last_was_data <= 1'b0;
`endif
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (dgrant) begin
                        req.wr    <= dwen;
                        req.addr  <= daddr;
                        req.store <= dstore;
                        req.width <= dwidth;
                        state     <= ARB_DBUSY;
`ifdef MEM_ARB_FAIRNESS_EN
                        last_was_data <= 1'b1;
`endif
                    end else if (iren) begin
                        req   <= fetch_req(iaddr);
                        state <= ARB_IBUSY;
`ifdef MEM_ARB_FAIRNESS_EN
                        last_was_data <= 1'b0;
`endif
                    end
                end
                ARB_IBUSY, ARB_DBUSY: begin
                    if (mem_ready) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Memory bus sees only latched request state, never live inputs.
    always_comb begin
        mem_ren   = (state == ARB_IBUSY) |
                    ((state == ARB_DBUSY) & ~req.wr);
        mem_wen   = (state == ARB_DBUSY) & req.wr;
        mem_addr  = req.addr;
        mem_store = req.store;
        mem_width = req.width;
        ihit      = (state == ARB_IBUSY) & mem_ready;
        dhit      = (state == ARB_DBUSY) & mem_ready;
        idata     = ihit ? mem_load : '0;
        dload     = dhit ? mem_load : '0;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded random + directed bench for memory_arbiter.
module tb_memory_arbiter;
    import rv32ima_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        iren;
    word_t       iaddr;
    word_t       idata;
    logic        ihit;
    logic        dren;
    logic        dwen;
    word_t       daddr;
    word_t       dstore;
    logic [1:0]  dwidth;
    word_t       dload;
    logic        dhit;
    logic        mem_ren;
    logic        mem_wen;
    word_t       mem_addr;
    word_t       mem_store;
    logic [1:0]  mem_width;
    word_t       mem_load;
    logic        mem_ready;

    memory_arbiter dut (
        .clk(clk), .nrst(nrst),
        .iren(iren), .iaddr(iaddr), .idata(idata), .ihit(ihit),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dwidth(dwidth), .dload(dload), .dhit(dhit),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_store(mem_store), .mem_width(mem_width),
        .mem_load(mem_load), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          data;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [1:0]  width;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_busy = 0;
    bit   m_last = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Transaction-level model: one access at a time, one idle gap after.
    always @(posedge clk) begin
        bit take_d;
        if (nrst) begin
            q.delete();
            m_busy = 0;
            m_last = 0;
        end else if (m_busy) begin
            if (mem_ready) m_busy = 0;
        end else begin
            take_d = dren | dwen;
`ifdef MEM_ARB_FAIRNESS_EN
            if (take_d && iren && m_last) take_d = 0;
`endif
            if (take_d) begin
                q.push_back('{1, dwen, daddr, dstore, dwidth});
                m_busy = 1;
                m_last = 1;
            end else if (iren) begin
                q.push_back('{0, 0, iaddr, 32'h0, LDST_WORD});
                m_busy = 1;
                m_last = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            if (q.size() == 0) begin
                chk("idle_ren", mem_ren, 0);
                chk("idle_wen", mem_wen, 0);
                chk("idle_ihit", ihit, 0);
                chk("idle_dhit", dhit, 0);
            end else begin
                e = q[0];
                chk("mem_ren", mem_ren, !e.wr);
                chk("mem_wen", mem_wen, e.wr);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_width", mem_width, e.width);
                if (e.wr) chk("mem_store", mem_store, e.store);
                chk("ihit", ihit, !e.data && mem_ready);
                chk("dhit", dhit, e.data && mem_ready);
                if (mem_ready) begin
                    if (!e.data) chk("idata", idata, mem_load);
                    else if (!e.wr) chk("dload", dload, mem_load);
                    void'(q.pop_front());
                end
            end
            if (!ihit) chk("idata_zero", idata, 0);
            if (!dhit) chk("dload_zero", dload, 0);
        end
    end

    task automatic drv(input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] w, input bit rdy,
                       input logic [31:0] ld);
        @(posedge clk);
        #1;
        iren = ir; iaddr = ia;
        dren = dr; dwen = dw; daddr = da; dstore = ds; dwidth = w;
        mem_ready = rdy; mem_load = ld;
    endtask

    task automatic idle(input bit rdy);
        drv(0, 32'h0, 0, 0, 32'h0, 32'h0, 2'd0, rdy, 32'hBAD0BAD0);
    endtask

    initial begin
        nrst = 1; iren = 0; iaddr = 0; dren = 0; dwen = 0;
        daddr = 0; dstore = 0; dwidth = 0; mem_ready = 0; mem_load = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ren", mem_ren, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_store", mem_store, 0);
        chk("rst_width", mem_width, 0);
        chk("rst_idata", idata, 0);
        chk("rst_dload", dload, 0);
        #2 nrst = 0;

        // fetch only, ready on first busy cycle
        drv(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h13);
        idle(0);

        // store with three wait cycles, inputs wander mid-busy
        drv(0, 0, 0, 1, 32'h2000, 32'hDEADBEEF, LDST_WORD, 0, 0);
        drv(0, 0, 1, 0, 32'h9999, 32'h1111, LDST_BYTE, 0, 0);
        drv(0, 0, 0, 0, 32'h7777, 32'h2222, LDST_HALF, 0, 0);
        drv(0, 0, 0, 0, 32'h7777, 32'h2222, LDST_HALF, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0);

        // simultaneous requests held across several grants
        for (int i = 0; i < 8; i++)
            drv(1, 32'h400, 1, 0, 32'h3000, 0, LDST_WORD,
                (i % 2) == 1, 32'h55 + i);
        idle(1);
        idle(0);

        // fetch address changes mid-busy
        drv(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hCAFE);
        idle(0);
        idle(0);

        for (int i = 0; i < 3000; i++)
            drv($urandom % 2, $urandom, $urandom % 3 == 0,
                $urandom % 4 == 0, $urandom, $urandom, 2'($urandom),
                $urandom % 3 == 0, $urandom);

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain_timeout", q.size(), 0);
        idle(0);

        // reset during a data access abandons it
        drv(0, 0, 1, 0, 32'h3000, 0, LDST_WORD, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        #2 nrst = 1;
        #1;
        chk("rstbusy_ren", mem_ren, 0);
        chk("rstbusy_wen", mem_wen, 0);
        chk("rstbusy_dhit", dhit, 0);
        chk("rstbusy_dload", dload, 0);
        chk("rstbusy_addr", mem_addr, 0);
        @(posedge clk);
        #3 nrst = 0;
        repeat (4) idle(1);
        drv(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        idle(0);
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the datapath's separate instruction-fetch and data-access ports onto a single unified memory port. It sits between `datapath` and the memory model or cache. It latches one request at a time, holds it stable on the memory bus until the memory signals ready, and returns the hit and load data to the originating port. Data accesses have priority by default, so a load or store in flight is never starved by fetch.

## Interface
Parameters: none. All widths come from `rv32ima_pkg` (`word_t`, `LDST_WIDTH_W`).

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous, active-high reset. Asserted (1) resets immediately; this polarity is fixed for this block.
- `iren`  in  1  instruction read request from datapath.
- `iaddr`  in  32  instruction address.
- `idata`  out  32  instruction returned; valid when `ihit`=1.
- `ihit`  out  1  instruction request complete (single-cycle pulse).
- `dren`  in  1  data read request.
- `dwen`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  store data.
- `dwidth`  in  LDST_WIDTH_W  access width code.
- `dload`  out  32  load data; valid when `dhit`=1.
- `dhit`  out  1  data request complete (single-cycle pulse).
- `mem_ren`  out  1  memory read strobe.
- `mem_wen`  out  1  memory write strobe.
- `mem_addr`  out  32  memory address.
- `mem_store`  out  32  memory write data.
- `mem_width`  out  LDST_WIDTH_W  memory access width. Fetches drive the word code.
- `mem_load`  in  32  memory read data.
- `mem_ready`  in  1  memory completes the current access this cycle.

## Operation
- FSM states: `ARB_IDLE`, `ARB_IBUSY`, `ARB_DBUSY`.
- **ARB_IDLE:**
  - If `dren|dwen`: latch `daddr`, `dstore`, `dwidth`, `dwen` into request registers and go to `ARB_DBUSY`.
  - Else if `iren`: latch `iaddr` and go to `ARB_IBUSY`.
  - Else stay in `ARB_IDLE`.
- `dren` and `dwen` both high is treated as a write.
- **BUSY states:**
  - `mem_*` are driven only from the latched registers, never from live inputs.
  - In `ARB_IBUSY`, `mem_ren`=1.
  - In `ARB_DBUSY`, `mem_ren`=!wr and `mem_wen`=wr, where wr is the latched write flag.
- **Completion:** on `mem_ready` in `ARB_IBUSY`, `ihit`=1 and `idata`=`mem_load`, combinational pass-through. In `ARB_DBUSY`, `dhit`=1 and `dload`=`mem_load` (`dload` is don't-care on writes). The next state is `ARB_IDLE`.
- **Requester drops its request mid-BUSY:** the memory access still completes and the hit still pulses. The datapath ignores it.
- **Input changes mid-BUSY** (address, data, width) are ignored until the next `ARB_IDLE` sample.
- **Off-state outputs:** `ihit` and `dhit` are 0 except in the completion cycle. `idata` and `dload` are 0 when their hit is low.

## Timing
- Reset values:
  - State = `ARB_IDLE`.
  - All request registers = 0.
  - `mem_ren`, `mem_wen`, `ihit`, `dhit` = 0.
  - `mem_addr`, `mem_store`, `idata`, `dload` = 0.
  - `mem_width` = 0.
- Minimum latency is 2 cycles from request to hit: the IDLE sample cycle, then the BUSY cycle with `mem_ready`=1.
- After each completion there is exactly one `ARB_IDLE` cycle. This gives the datapath one edge to retire or reissue the request.
- Back-to-back requests achieve at best one access per 2 cycles.
- Reset asserted mid-BUSY: outputs return to reset values immediately and asynchronously. The pending access is abandoned and no hit is issued.
- `mem_ready` asserted while in `ARB_IDLE` is ignored.

## Configuration
- Macro: `MEM_ARB_FAIRNESS_EN`.
- **Defined:**
  - A 1-bit `last_was_data` register is set on each data grant and cleared on each instruction grant. It resets to 0.
  - In `ARB_IDLE`, if both a fetch and a data request are pending and `last_was_data`=1, the fetch wins. Otherwise the data request wins.
- **Undefined:** fixed data priority. The register is not present.

## Structure
- In `rv32ima_pkg`:
  - typedef `arb_state_t` enum {`ARB_IDLE`, `ARB_IBUSY`, `ARB_DBUSY`}.
  - constant `LDST_WORD` for the fetch width code.
- Flat module with a single FSM, next-state/output combinational logic and request registers. No sub-module.

## Test plan
- **Fetch only:** `iren`=1, `iaddr`=0x100, `mem_ready` high 1 cycle after grant, `mem_load`=0x00000013 -> `mem_ren`=1, `mem_addr`=0x100, then `ihit` pulses 1 cycle with `idata`=0x00000013.
- **Store:** `dwen`=1, `daddr`=0x2000, `dstore`=0xDEADBEEF, `dwidth`=word, memory waits 3 cycles -> `mem_wen` held with stable addr/data for 3 cycles, then one `dhit` pulse and `mem_wen`=0 next cycle.
- **Simultaneous** `iren`=1 and `dren`=1 (0x3000, `mem_load`=0x55) -> data is served first (`dhit`, `dload`=0x55), then the fetch, with no `ihit` during the data access. With `MEM_ARB_FAIRNESS_EN`, a second simultaneous pair is served fetch first.
- **Input change mid-BUSY:** `iaddr` changes from 0x100 to 0x200 while `ARB_IBUSY` -> `mem_addr` stays 0x100 until completion.
- **Reset mid-BUSY:** `nrst`=1 during `ARB_DBUSY` -> `mem_ren`, `mem_wen`, `dhit` go to 0 in the same cycle. After release the state is `ARB_IDLE` and a stale `mem_ready` is ignored.
